// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single external memory port between the CPU
// datapath and the front-panel loader. Each access holds the strobe for
// WAIT_CYCLES+1 cycles and is then acknowledged with a one-cycle ack pulse.
// Optional macro MEM_ARB_CPU_PRIO_EN: fixed CPU priority on contention
// instead of round-robin arbitration.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // Counter value at which the final strobe cycle ends.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       we_r;
  logic       pick_cpu;
  logic       pick_ldr;

`ifndef MEM_ARB_CPU_PRIO_EN
  // High when the CPU was served by the most recent completed access.
  logic       last_cpu;
`endif

  // Winner that IDLE would accept if it sampled the requests this cycle.
  always_comb begin
    pick_cpu = 1'b0;
    pick_ldr = 1'b0;
`ifdef MEM_ARB_CPU_PRIO_EN
    pick_cpu = cpu_req;
`else
    pick_cpu = cpu_req && (!ldr_req || !last_cpu);
`endif
    pick_ldr = ldr_req && !pick_cpu;
  end

  assign busy = (state != IDLE);

  // Access sequencer: arbitrate in IDLE, strobe memory in ACCESS, ack in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      we_r      <= 1'b0;
      cpu_gnt   <= 1'b0;
      ldr_gnt   <= 1'b0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
`ifndef MEM_ARB_CPU_PRIO_EN
      last_cpu  <= 1'b0;
`endif
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_cpu || pick_ldr) begin
            state    <= ACCESS;
            wait_cnt <= '0;
            cpu_gnt  <= pick_cpu;
            ldr_gnt  <= pick_ldr;
            if (pick_cpu) begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              we_r      <= cpu_we;
              mem_read  <= !cpu_we;
              mem_write <= cpu_we;
            end else begin
              mem_addr  <= ldr_addr;
              mem_wdata <= ldr_wdata;
              we_r      <= ldr_we;
              mem_read  <= !ldr_we;
              mem_write <= ldr_we;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == WAIT_LAST) begin
            state     <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cpu_ack   <= cpu_gnt;
            ldr_ack   <= ldr_gnt;
            if (!we_r) begin
              rdata <= mem_rdata;
            end
`ifndef MEM_ARB_CPU_PRIO_EN
            last_cpu <= cpu_gnt;
`endif
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          cpu_gnt <= 1'b0;
          ldr_gnt <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A WAIT_CYCLES=1
// instance is exercised with directed and random traffic against a
// transaction-level model; a WAIT_CYCLES=0 instance checks the short path.
module tb_mem_arbiter;

  localparam int WAIT = 1;

  logic        clk = 1'b0;
  logic        rst;

  logic        cpu_req, cpu_we, cpu_gnt, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        ldr_req, ldr_we, ldr_gnt, ldr_ack;
  logic [15:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_read, mem_write, busy;

  logic        z_cpu_req, z_cpu_we, z_cpu_gnt, z_cpu_ack;
  logic [15:0] z_cpu_addr;
  logic [7:0]  z_cpu_wdata;
  logic        z_ldr_gnt, z_ldr_ack;
  logic [7:0]  z_rdata, z_mem_wdata, z_mem_rdata;
  logic [15:0] z_mem_addr;
  logic        z_mem_read, z_mem_write, z_busy;

  int pass_cnt;
  int fail_cnt;
  int total_cnt;

  // Model state: who was served last and what rdata should currently hold.
  bit          prev_cpu;
  logic [7:0]  exp_rdata;

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [7:0] memHash(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hB5;
  endfunction

  assign mem_rdata   = memHash(mem_addr);
  assign z_mem_rdata = memHash(z_mem_addr);

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_ack(ldr_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
    .cpu_gnt(z_cpu_gnt), .cpu_ack(z_cpu_ack),
    .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(16'h0000), .ldr_wdata(8'h00),
    .ldr_gnt(z_ldr_gnt), .ldr_ack(z_ldr_ack),
    .rdata(z_rdata), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata),
    .mem_read(z_mem_read), .mem_write(z_mem_write), .busy(z_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit c_req, input bit c_we, input logic [15:0] c_addr,
                               input logic [7:0] c_wd, input bit l_req, input bit l_we,
                               input logic [15:0] l_addr, input logic [7:0] l_wd);
    cpu_req   = c_req;
    cpu_we    = c_we;
    cpu_addr  = c_addr;
    cpu_wdata = c_wd;
    ldr_req   = l_req;
    ldr_we    = l_we;
    ldr_addr  = l_addr;
    ldr_wdata = l_wd;
  endtask

  // Arbitration rule: a lone requester wins; on contention the one not served last wins.
  function automatic bit expectCpu(input bit c, input bit l);
    if (c && !l) return 1'b1;
    if (l && !c) return 1'b0;
`ifdef MEM_ARB_CPU_PRIO_EN
    return 1'b1;
`else
    return !prev_cpu;
`endif
  endfunction

  // Follows one access from the negedge where it is requested to the idle cycle after ack.
  task automatic runTxn(input string tag, input bit exp_cpu, input bit exp_we,
                        input logic [15:0] exp_addr, input logic [7:0] exp_wdata,
                        input bit drop, input bit disturb);
    int cyc, gnt_cyc, ack_cyc, strobes, bad_strobe, bad_mutex;
    cyc = 0; gnt_cyc = -1; ack_cyc = -1; strobes = 0; bad_strobe = 0; bad_mutex = 0;
    if (!exp_we) exp_rdata = memHash(exp_addr);
    while (ack_cyc < 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if ((cpu_gnt && ldr_gnt) || (cpu_ack && ldr_ack) || (mem_read && mem_write)) bad_mutex++;
      if (gnt_cyc < 0 && (cpu_gnt || ldr_gnt)) begin
        gnt_cyc = cyc;
        if (disturb) begin
          cpu_addr  = ~cpu_addr;
          cpu_wdata = ~cpu_wdata;
          cpu_we    = ~cpu_we;
          cpu_req   = 1'b0;
        end
      end
      if (mem_read || mem_write) begin
        strobes++;
        if (mem_addr !== exp_addr || mem_write !== exp_we ||
            (exp_we && mem_wdata !== exp_wdata)) bad_strobe++;
      end
      if (cpu_ack || ldr_ack) begin
        ack_cyc = cyc;
        checkOutput({tag, " ack_owner"}, 32'(cpu_ack), 32'(exp_cpu));
        checkOutput({tag, " gnt_at_ack"}, {30'b0, cpu_gnt, ldr_gnt}, {30'b0, exp_cpu, !exp_cpu});
        checkOutput({tag, " rdata"}, 32'(rdata), 32'(exp_rdata));
        if (drop) begin
          if (exp_cpu) cpu_req = 1'b0;
          else ldr_req = 1'b0;
        end
      end
    end
    checkOutput({tag, " ack_seen"}, 32'(ack_cyc >= 0), 32'd1);
    checkOutput({tag, " gnt_delay"}, gnt_cyc, 32'd1);
    checkOutput({tag, " ack_latency"}, ack_cyc - gnt_cyc, WAIT + 1);
    checkOutput({tag, " strobe_cycles"}, strobes, WAIT + 1);
    checkOutput({tag, " strobe_fields"}, bad_strobe, 32'd0);
    checkOutput({tag, " mutex"}, bad_mutex, 32'd0);
    @(negedge clk);
    checkOutput({tag, " idle_after"}, {27'b0, cpu_ack, ldr_ack, cpu_gnt, ldr_gnt, busy}, 32'd0);
    prev_cpu = exp_cpu;
  endtask

  initial begin
    bit          c, l, cwe, lwe, w;
    logic [15:0] caddr, laddr;
    logic [7:0]  cwd, lwd;
    int          noack, z_strobes, z_acks, z_first, z_last, z_badgap;

    pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
    prev_cpu = 1'b0; exp_rdata = 8'h00;
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    z_cpu_req = 1'b0; z_cpu_we = 1'b0; z_cpu_addr = 16'h0000; z_cpu_wdata = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", {25'b0, cpu_gnt, cpu_ack, ldr_gnt, ldr_ack, mem_read, mem_write, busy}, 32'd0);
    checkOutput("reset_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_data", {16'b0, rdata, mem_wdata}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_no_req", 32'(busy), 32'd0);

    $display("[TB] directed CPU read and loader write");
    applyStimulus(1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00);
    runTxn("cpu_read", 1, 0, 16'h0010, 8'h00, 1, 0);
    checkOutput("cpu_read_value", 32'(rdata), 32'h0000_00A5);
    applyStimulus(0, 0, 16'h0000, 8'h00, 1, 1, 16'h0123, 8'h3C);
    runTxn("ldr_write", 0, 1, 16'h0123, 8'h3C, 1, 0);
    checkOutput("ldr_write_rdata_kept", 32'(rdata), 32'h0000_00A5);

    $display("[TB] continuous contention after reset");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prev_cpu = 1'b0; exp_rdata = 8'h00;
    applyStimulus(1, 0, 16'h0200, 8'h00, 1, 1, 16'h0300, 8'h77);
    for (int i = 0; i < 4; i++) begin
      w = expectCpu(1, 1);
      runTxn($sformatf("contend%0d", i), w, !w, w ? 16'h0200 : 16'h0300, w ? 8'h00 : 8'h77, 0, 0);
    end
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);

    $display("[TB] mid-access disturbance");
    applyStimulus(1, 0, 16'h0ABC, 8'h11, 0, 0, 16'h0000, 8'h00);
    runTxn("cpu_disturb", 1, 0, 16'h0ABC, 8'h11, 1, 1);

    $display("[TB] reset during access");
    applyStimulus(1, 0, 16'h0040, 8'h00, 0, 0, 16'h0000, 8'h00);
    runTxn("pre_rst", 1, 0, 16'h0040, 8'h00, 1, 0);
    applyStimulus(1, 0, 16'h0050, 8'h00, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("rst_pre_strobe", {30'b0, cpu_gnt, mem_read}, 32'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_drop", {28'b0, cpu_gnt, mem_read, mem_write, busy}, 32'd0);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    prev_cpu = 1'b0; exp_rdata = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    noack = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ack || ldr_ack || busy) noack++;
    end
    checkOutput("rst_no_ack", noack, 32'd0);
    checkOutput("rst_rdata", 32'(rdata), 32'd0);
    applyStimulus(1, 0, 16'h0060, 8'h00, 1, 1, 16'h0070, 8'h5D);
    w = expectCpu(1, 1);
    runTxn("post_rst_a", w, !w, w ? 16'h0060 : 16'h0070, w ? 8'h00 : 8'h5D, 1, 0);
    runTxn("post_rst_b", !w, w, w ? 16'h0070 : 16'h0060, w ? 8'h5D : 8'h00, 1, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 20; i++) begin
      c = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      if (!c && !l) c = 1'b1;
      cwe = 1'($urandom_range(0, 1));
      lwe = 1'($urandom_range(0, 1));
      caddr = 16'($urandom);
      laddr = 16'($urandom);
      cwd = 8'($urandom);
      lwd = 8'($urandom);
      applyStimulus(c, cwe, caddr, cwd, l, lwe, laddr, lwd);
      w = expectCpu(c, l);
      runTxn($sformatf("rnd%0d_a", i), w, w ? cwe : lwe, w ? caddr : laddr, w ? cwd : lwd, 1, 0);
      if (c && l) begin
        runTxn($sformatf("rnd%0d_b", i), !w, w ? lwe : cwe, w ? laddr : caddr, w ? lwd : cwd, 1, 0);
      end
    end

    $display("[TB] zero wait cycles, back-to-back CPU reads");
    z_strobes = 0; z_acks = 0; z_first = -1; z_last = 0; z_badgap = 0;
    z_cpu_addr = 16'h0010; z_cpu_we = 1'b0; z_cpu_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (z_mem_read || z_mem_write) z_strobes++;
      if (z_cpu_ack) begin
        if (z_first < 0) z_first = k;
        else if (k - z_last != 3) z_badgap++;
        z_last = k;
        z_acks++;
      end
    end
    z_cpu_req = 1'b0;
    checkOutput("w0_first_ack", z_first, 32'd2);
    checkOutput("w0_ack_count", z_acks, 32'd4);
    checkOutput("w0_ack_spacing", z_badgap, 32'd0);
    checkOutput("w0_strobe_cycles", z_strobes, 32'd4);
    checkOutput("w0_rdata", 32'(z_rdata), 32'h0000_00A5);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
